// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Multi-cycle sequencing controller for the 16-bit MIPS datapath. Each
// instruction is stepped through FETCH / DECODE / EXEC / MEM / WB, with one
// set of datapath enables per state. The block also handles the data-memory
// ready handshake, a memory-timeout fault, and run/halt control.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   run          in   1 = execute, 0 = stop at the next instruction boundary
//   opcode[3:0]  in   Instr[15:12] from the instruction register
//   eq           in   ALU equality flag (selects the BNE target)
//   mem_ready    in   data memory finished the current access this cycle
//   ir_load      out  load instruction register
//   pc_write     out  PC update strobe; one pulse retires one instruction
//   pc_src       out  0 = PC+1, 1 = branch target
//   reg_dst      out  1 = write Caddr, 0 = write Baddr
//   reg_write    out  register file write enable
//   alu_src      out  0 = register B, 1 = sign-extended offset
//   alu_op[3:0]  out  ALU operation
//   mem_read     out  data memory read request
//   mem_write    out  data memory write request
//   mem_to_reg   out  1 = write-back data comes from memory
//   halted       out  controller is in HALT
//   fault        out  sticky memory-timeout flag
//   state[2:0]   out  current state encoding
//   instr_count  out  retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [3:0]  opcode,
    input  logic        eq,
    input  logic        mem_ready,
    output logic        ir_load,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src,
    output logic [3:0]  alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        halted,
    output logic        fault,
    output logic [2:0]  state,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_RMAX = 4'hA;
    localparam logic [3:0] OP_LW   = 4'hB;
    localparam logic [3:0] OP_SW   = 4'hC;
    localparam logic [3:0] OP_BNE  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_NOP  = 4'hF;
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;

    state_t      st_q;
    logic [3:0]  op_q;
    logic [3:0]  wcnt_q;
    logic        fault_q;
    logic [15:0] icnt_q;

    // Every instruction boundary funnels through here so a dropped run
    // parks the controller in IDLE instead of fetching.
    function automatic state_t boundary_next(input logic r);
        return r ? S_FETCH : S_IDLE;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= S_IDLE;
            op_q    <= 4'h0;
            wcnt_q  <= 4'h0;
            fault_q <= 1'b0;
            icnt_q  <= 16'h0000;
        end else begin
            if (pc_write) begin
                icnt_q <= icnt_q + 16'd1;
            end
            case (st_q)
                S_IDLE: begin
                    if (run) begin
                        st_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    st_q <= S_DECODE;
                end
                S_DECODE: begin
                    op_q <= opcode;
                    if (opcode == OP_HALT) begin
                        st_q <= S_HALT;
                    end else if (opcode == OP_NOP) begin
                        st_q <= boundary_next(run);
                    end else begin
                        st_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op_q <= OP_RMAX) begin
                        st_q <= S_WB;
                    end else if (op_q == OP_LW || op_q == OP_SW) begin
                        wcnt_q <= 4'h0;
                        st_q   <= S_MEM;
                    end else if (op_q == OP_BNE) begin
                        st_q <= boundary_next(run);
                    end else begin
                        st_q <= S_IDLE;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        st_q <= (op_q == OP_SW) ? boundary_next(run) : S_WB;
                    end else if (wcnt_q == 4'hF) begin
                        // Sixteenth cycle still not ready: give up on the bus.
                        fault_q <= 1'b1;
                        st_q    <= S_HALT;
                    end else begin
                        wcnt_q <= wcnt_q + 4'd1;
                    end
                end
                S_WB: begin
                    st_q <= boundary_next(run);
                end
                S_HALT: begin
                    st_q <= S_HALT;
                end
                default: begin
                    st_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        case (st_q)
            S_FETCH: begin
                ir_load = 1'b1;
            end
            S_DECODE: begin
                // op_q is only captured at the end of DECODE, so the NOP
                // retire strobe has to look at the live opcode.
                if (opcode == OP_NOP) begin
                    pc_write = 1'b1;
                end
            end
            S_EXEC: begin
                if (op_q <= OP_RMAX) begin
                    alu_op = op_q;
                end else if (op_q == OP_LW || op_q == OP_SW) begin
                    alu_src = 1'b1;
                end else if (op_q == OP_BNE) begin
                    alu_op   = ALU_SUB;
                    pc_write = 1'b1;
                    pc_src   = ~eq;
                end
            end
            S_MEM: begin
                alu_src   = 1'b1;
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q == OP_SW);
                pc_write  = mem_ready && (op_q == OP_SW);
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                if (op_q == OP_LW) begin
                    mem_to_reg = 1'b1;
                    alu_src    = 1'b1;
                end else begin
                    reg_dst = 1'b1;
                    alu_op  = op_q;
                end
            end
            default: begin
            end
        endcase
    end

    assign halted      = (st_q == S_HALT);
    assign fault       = fault_q;
    assign state       = st_q;
    assign instr_count = icnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Table-driven bench for the multi-cycle controller. Each table row holds
// the inputs for one clock cycle and the outputs expected in that cycle.
// Expected records are queued when a row is driven and popped when the DUT
// outputs are sampled. Reset-in-flight and a long NOP stream are hand-written
// sequences after the table.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [3:0]  opcode;
    logic        eq;
    logic        mem_ready;
    logic        ir_load;
    logic        pc_write;
    logic        pc_src;
    logic        reg_dst;
    logic        reg_write;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        halted;
    logic        fault;
    logic [2:0]  state;
    logic [15:0] instr_count;

    mips_multicycle_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .opcode      (opcode),
        .eq          (eq),
        .mem_ready   (mem_ready),
        .ir_load     (ir_load),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .reg_dst     (reg_dst),
        .reg_write   (reg_write),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .halted      (halted),
        .fault       (fault),
        .state       (state),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl bit order: ir_load pc_write pc_src reg_dst reg_write alu_src
    //                alu_op[3:0] mem_read mem_write mem_to_reg
    logic [12:0] act_ctl;
    assign act_ctl = {ir_load, pc_write, pc_src, reg_dst, reg_write, alu_src,
                      alu_op, mem_read, mem_write, mem_to_reg};

    typedef struct {
        logic        run;
        logic [3:0]  op;
        logic        eq;
        logic        rdy;
        logic [2:0]  st;
        logic [12:0] ctl;
        logic        h;
        logic        f;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        int          id;
        logic [2:0]  st;
        logic [12:0] ctl;
        logic        h;
        logic        f;
        logic [15:0] cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [12:0] kF, kLE, kLM, kLW, kSM, kSD, kNP, kRE2, kRW2, kREA, kRWA, kB0, kB1;

    function automatic logic [12:0] c(input logic irl, input logic pcw, input logic pcs,
                                      input logic rd, input logic rw, input logic as,
                                      input logic [3:0] aop, input logic mr,
                                      input logic mw, input logic m2r);
        return {irl, pcw, pcs, rd, rw, as, aop, mr, mw, m2r};
    endfunction

    task automatic add(input logic r, input logic [3:0] op, input logic e, input logic rdy,
                       input logic [2:0] st, input logic [12:0] ctl, input logic h,
                       input logic f, input logic [15:0] cnt);
        vec_t v;
        v.run = r; v.op = op; v.eq = e; v.rdy = rdy;
        v.st = st; v.ctl = ctl; v.h = h; v.f = f; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic expect_out(input int id, input logic [2:0] st, input logic [12:0] ctl,
                              input logic h, input logic f, input logic [15:0] cnt);
        exp_t e;
        e.id = id; e.st = st; e.ctl = ctl; e.h = h; e.f = f; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic sample_out();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard empty at sample time");
        end else begin
            e = sb.pop_front();
            if ({state, act_ctl, halted, fault, instr_count} !== {e.st, e.ctl, e.h, e.f, e.cnt}) begin
                errors++;
                $display("FAIL vec%0d st/ctl/halted/fault/cnt got %0d/%b/%b/%b/%h want %0d/%b/%b/%b/%h",
                         e.id, state, act_ctl, halted, fault, instr_count,
                         e.st, e.ctl, e.h, e.f, e.cnt);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; opcode = 4'h0; eq = 1'b0; mem_ready = 1'b0;

        kF   = c(1,0,0,0,0,0,4'h0,0,0,0);
        kLE  = c(0,0,0,0,0,1,4'h0,0,0,0);
        kLM  = c(0,0,0,0,0,1,4'h0,1,0,0);
        kLW  = c(0,1,0,0,1,1,4'h0,0,0,1);
        kSM  = c(0,0,0,0,0,1,4'h0,0,1,0);
        kSD  = c(0,1,0,0,0,1,4'h0,0,1,0);
        kNP  = c(0,1,0,0,0,0,4'h0,0,0,0);
        kRE2 = c(0,0,0,0,0,0,4'h2,0,0,0);
        kRW2 = c(0,1,0,1,1,0,4'h2,0,0,0);
        kREA = c(0,0,0,0,0,0,4'hA,0,0,0);
        kRWA = c(0,1,0,1,1,0,4'hA,0,0,0);
        kB0  = c(0,1,1,0,0,0,4'h1,0,0,0);
        kB1  = c(0,1,0,0,0,0,4'h1,0,0,0);

        // R-type 0010: IDLE, FETCH, DECODE, EXEC, WB (mem_ready ignored outside MEM)
        add(1,4'h2,0,0, 3'd0, 13'd0, 0,0, 16'd0);
        add(1,4'h2,0,0, 3'd1, kF,    0,0, 16'd0);
        add(1,4'h2,0,0, 3'd2, 13'd0, 0,0, 16'd0);
        add(1,4'h2,0,1, 3'd3, kRE2,  0,0, 16'd0);
        add(1,4'h2,0,1, 3'd5, kRW2,  0,0, 16'd0);
        // LW, 3 not-ready MEM cycles then ready: 8 cycles FETCH..WB
        add(1,4'hB,0,1, 3'd1, kF,    0,0, 16'd1);
        add(1,4'hB,0,1, 3'd2, 13'd0, 0,0, 16'd1);
        add(1,4'hB,0,1, 3'd3, kLE,   0,0, 16'd1);
        for (int i = 0; i < 3; i++) add(1,4'hB,0,0, 3'd4, kLM, 0,0, 16'd1);
        add(1,4'hB,0,1, 3'd4, kLM,   0,0, 16'd1);
        add(1,4'hB,0,0, 3'd5, kLW,   0,0, 16'd1);
        // BNE, eq=0 then eq=1
        add(1,4'hD,0,0, 3'd1, kF,    0,0, 16'd2);
        add(1,4'hD,0,0, 3'd2, 13'd0, 0,0, 16'd2);
        add(1,4'hD,0,0, 3'd3, kB0,   0,0, 16'd2);
        add(1,4'hD,1,0, 3'd1, kF,    0,0, 16'd3);
        add(1,4'hD,1,0, 3'd2, 13'd0, 0,0, 16'd3);
        add(1,4'hD,1,0, 3'd3, kB1,   0,0, 16'd3);
        // LW with run dropped in EXEC: completes through WB, then IDLE
        add(1,4'hB,0,0, 3'd1, kF,    0,0, 16'd4);
        add(1,4'hB,0,0, 3'd2, 13'd0, 0,0, 16'd4);
        add(0,4'hB,0,0, 3'd3, kLE,   0,0, 16'd4);
        add(0,4'hB,0,1, 3'd4, kLM,   0,0, 16'd4);
        add(0,4'hB,0,0, 3'd5, kLW,   0,0, 16'd4);
        add(0,4'hB,0,0, 3'd0, 13'd0, 0,0, 16'd5);
        add(1,4'hB,0,0, 3'd0, 13'd0, 0,0, 16'd5);
        // NOP twice; second one with run=0 at DECODE parks in IDLE
        add(1,4'hF,0,0, 3'd1, kF,    0,0, 16'd5);
        add(1,4'hF,0,0, 3'd2, kNP,   0,0, 16'd5);
        add(1,4'hF,0,0, 3'd1, kF,    0,0, 16'd6);
        add(0,4'hF,0,0, 3'd2, kNP,   0,0, 16'd6);
        add(1,4'hF,0,0, 3'd0, 13'd0, 0,0, 16'd7);
        // SW with one wait cycle; retires in MEM
        add(1,4'hC,0,0, 3'd1, kF,    0,0, 16'd7);
        add(1,4'hC,0,0, 3'd2, 13'd0, 0,0, 16'd7);
        add(1,4'hC,0,0, 3'd3, kLE,   0,0, 16'd7);
        add(1,4'hC,0,0, 3'd4, kSM,   0,0, 16'd7);
        add(1,4'hC,0,1, 3'd4, kSD,   0,0, 16'd7);
        // SW ready on the 16th MEM cycle: last chance, no timeout
        add(1,4'hC,0,0, 3'd1, kF,    0,0, 16'd8);
        add(1,4'hC,0,0, 3'd2, 13'd0, 0,0, 16'd8);
        add(1,4'hC,0,0, 3'd3, kLE,   0,0, 16'd8);
        for (int i = 0; i < 15; i++) add(1,4'hC,0,0, 3'd4, kSM, 0,0, 16'd8);
        add(1,4'hC,0,1, 3'd4, kSD,   0,0, 16'd8);
        // Highest R-type opcode 1010
        add(1,4'hA,0,0, 3'd1, kF,    0,0, 16'd9);
        add(1,4'hA,0,0, 3'd2, 13'd0, 0,0, 16'd9);
        add(1,4'hA,0,0, 3'd3, kREA,  0,0, 16'd9);
        add(1,4'hA,0,0, 3'd5, kRWA,  0,0, 16'd9);
        // SW timeout: 16 not-ready MEM cycles, then HALT with fault
        add(1,4'hC,0,0, 3'd1, kF,    0,0, 16'd10);
        add(1,4'hC,0,0, 3'd2, 13'd0, 0,0, 16'd10);
        add(1,4'hC,0,0, 3'd3, kLE,   0,0, 16'd10);
        for (int i = 0; i < 16; i++) add(1,4'hC,0,0, 3'd4, kSM, 0,0, 16'd10);
        add(1,4'hC,0,1, 3'd6, 13'd0, 1,1, 16'd10);
        add(0,4'hC,0,0, 3'd6, 13'd0, 1,1, 16'd10);
        add(1,4'hF,0,0, 3'd6, 13'd0, 1,1, 16'd10);
        add(1,4'hF,0,1, 3'd6, 13'd0, 1,1, 16'd10);

        // Reset values while rst_n is low
        #2;
        expect_out(900, 3'd0, 13'd0, 0,0, 16'd0);
        sample_out();
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run = tbl[i].run; opcode = tbl[i].op; eq = tbl[i].eq; mem_ready = tbl[i].rdy;
            expect_out(i, tbl[i].st, tbl[i].ctl, tbl[i].h, tbl[i].f, tbl[i].cnt);
            @(negedge clk);
            sample_out();
            @(posedge clk);
            #1;
        end

        // Only reset leaves HALT; fault clears with it
        rst_n = 1'b0;
        #1;
        expect_out(910, 3'd0, 13'd0, 0,0, 16'd0);
        sample_out();
        @(posedge clk);
        #1 rst_n = 1'b1; run = 1'b1; opcode = 4'hF; mem_ready = 1'b0; eq = 1'b0;

        // 500 back-to-back NOPs at 2 cycles each
        repeat (1 + 2 * 500) @(posedge clk);
        #1;
        expect_out(920, 3'd1, kF, 0,0, 16'd500);
        @(negedge clk);
        sample_out();

        // SW into MEM, then reset mid-access
        opcode = 4'hC;
        repeat (3) @(posedge clk);
        #1;
        expect_out(930, 3'd4, kSM, 0,0, 16'd500);
        @(negedge clk);
        sample_out();
        mem_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        expect_out(931, 3'd0, 13'd0, 0,0, 16'd0);
        sample_out();
        @(posedge clk);
        #1;
        expect_out(932, 3'd0, 13'd0, 0,0, 16'd0);
        sample_out();
        rst_n = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        expect_out(933, 3'd1, kF, 0,0, 16'd0);
        @(negedge clk);
        sample_out();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
